// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester handshakes and the data-memory bus that the
// dmem_arbiter sits between.
//
// Signals (per requester n = 0, 1):
//   rn_req, rn_we, rn_addr, rn_wdata : request side, driven by the requester
//   rn_gnt, rn_done, rn_rdata, rn_err: response side, driven by the arbiter
// Memory side:
//   mem_ewr, mem_erd, mem_addr, mem_rdir : driven by the arbiter
//   mem_mout                             : combinational read data from memory
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_done;
    logic [DW-1:0] r0_rdata;
    logic          r0_err;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_done;
    logic [DW-1:0] r1_rdata;
    logic          r1_err;

    logic          mem_ewr;
    logic          mem_erd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdir;
    logic [DW-1:0] mem_mout;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_mout,
        output r0_gnt, r0_done, r0_rdata, r0_err,
        output r1_gnt, r1_done, r1_rdata, r1_err,
        output mem_ewr, mem_erd, mem_addr, mem_rdir
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_mout,
        input  r0_gnt, r0_done, r0_rdata, r0_err,
        input  r1_gnt, r1_done, r1_rdata, r1_err,
        input  mem_ewr, mem_erd, mem_addr, mem_rdir
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the 32-word data memory between requester 0 (CPU load/store stage)
// and requester 1 (loader/debug port). Each transaction runs IDLE -> ACCESS ->
// RESP, so one access completes every three cycles. All outputs are registered.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - dmem_arbiter_if.slave: both requester handshakes and the memory bus
//
// Configuration macro:
//   DMEM_ARB_RR_EN - defined: round-robin on ties (the requester that did not
//                    own the previous transaction wins).
//                    undefined: fixed priority, requester 0 always wins a tie.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 32
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [AW-1:0] DEPTH_LIMIT = AW'(DEPTH);

    state_t        r_state;
    logic          r_owner;
    logic          r_errPending;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_done0;
    logic          r_done1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_memEwr;
    logic          r_memErd;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
`ifdef DMEM_ARB_RR_EN
    logic          r_lastOwner;
`endif

    logic          w_anyReq;
    logic          w_pick1;
    logic          w_selWe;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selWdata;
    logic          w_inRange;

    // Owner selection for the next transaction. Only consulted in IDLE, so the
    // request inputs are ignored while a transaction is in flight.
    always_comb begin
        w_anyReq = bus.r0_req | bus.r1_req;
`ifdef DMEM_ARB_RR_EN
        // On a tie, requester 1 wins only if requester 0 owned the last access.
        w_pick1 = bus.r1_req & (~bus.r0_req | ~r_lastOwner);
`else
        w_pick1 = bus.r1_req & ~bus.r0_req;
`endif
        w_selWe    = w_pick1 ? bus.r1_we    : bus.r0_we;
        w_selAddr  = w_pick1 ? bus.r1_addr  : bus.r0_addr;
        w_selWdata = w_pick1 ? bus.r1_wdata : bus.r0_wdata;
        w_inRange  = (w_selAddr < DEPTH_LIMIT);
    end

    // Transaction sequencer. IDLE latches the winner and raises exactly one
    // memory enable (none for an out-of-range address), ACCESS captures the
    // read data and raises done, RESP clears everything. A reset during
    // ACCESS still lets the memory see its enable at that edge, but no done
    // is ever issued for the aborted transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_errPending <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_memEwr     <= 1'b0;
            r_memErd     <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
`ifdef DMEM_ARB_RR_EN
            r_lastOwner  <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state      <= ACCESS;
                        r_owner      <= w_pick1;
                        r_gnt0       <= ~w_pick1;
                        r_gnt1       <= w_pick1;
                        r_memEwr     <= w_selWe & w_inRange;
                        r_memErd     <= ~w_selWe & w_inRange;
                        r_memAddr    <= w_selAddr;
                        r_memWdata   <= w_selWdata;
                        r_errPending <= ~w_inRange;
`ifdef DMEM_ARB_RR_EN
                        r_lastOwner  <= w_pick1;
`endif
                    end
                end
                ACCESS: begin
                    r_state    <= RESP;
                    r_memEwr   <= 1'b0;
                    r_memErd   <= 1'b0;
                    r_memAddr  <= '0;
                    r_memWdata <= '0;
                    if (r_owner) begin
                        r_done1  <= 1'b1;
                        r_err1   <= r_errPending;
                        r_rdata1 <= r_memErd ? bus.mem_mout : '0;
                    end else begin
                        r_done0  <= 1'b1;
                        r_err0   <= r_errPending;
                        r_rdata0 <= r_memErd ? bus.mem_mout : '0;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_err0   <= 1'b0;
                    r_err1   <= 1'b0;
                    r_rdata0 <= '0;
                    r_rdata1 <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Every output comes straight from a register.
    assign bus.r0_gnt   = r_gnt0;
    assign bus.r0_done  = r_done0;
    assign bus.r0_err   = r_err0;
    assign bus.r0_rdata = r_rdata0;
    assign bus.r1_gnt   = r_gnt1;
    assign bus.r1_done  = r_done1;
    assign bus.r1_err   = r_err1;
    assign bus.r1_rdata = r_rdata1;
    assign bus.mem_ewr  = r_memEwr;
    assign bus.mem_erd  = r_memErd;
    assign bus.mem_addr = r_memAddr;
    assign bus.mem_rdir = r_memWdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter: drives both requesters, hosts the 32-word data
// memory, and keeps a transaction-level reference model (owner choice,
// memory contents) that the DUT outputs are compared against.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic memClear;
    int   checks;
    int   errors;

    logic [31:0] envMem [0:31];
    logic [31:0] refMem [0:31];
    logic        modelLast;

    dmem_arbiter_if #(.DW(32), .AW(32)) bus ();

    dmem_arbiter #(.DW(32), .AW(32), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The data memory: combinational read, write on the rising edge whenever
    // the arbiter's write enable is high (reset does not block it).
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 32; i++) envMem[i] <= 32'd0;
        end else if (bus.mem_ewr && bus.mem_addr < 32) begin
            envMem[bus.mem_addr[4:0]] <= bus.mem_rdir;
        end
    end

    assign bus.mem_mout = (bus.mem_addr < 32) ? envMem[bus.mem_addr[4:0]] : 32'd0;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.r0_req   = q0;
        bus.r0_we    = w0;
        bus.r0_addr  = a0;
        bus.r0_wdata = d0;
        bus.r1_req   = q1;
        bus.r1_we    = w1;
        bus.r1_addr  = a1;
        bus.r1_wdata = d1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"}, {24'd0, bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done,
                                      bus.r0_err, bus.r1_err, bus.mem_ewr, bus.mem_erd}, 32'd0);
        checkOutput({tag, "_rdata0"}, bus.r0_rdata, 32'd0);
        checkOutput({tag, "_rdata1"}, bus.r1_rdata, 32'd0);
        checkOutput({tag, "_maddr"}, bus.mem_addr, 32'd0);
        checkOutput({tag, "_mwdata"}, bus.mem_rdir, 32'd0);
    endtask

    // Reference arbitration rule: lone requester wins; on a tie, round robin
    // picks whoever did not own the last transaction, fixed priority picks 0.
    function automatic int pickOwner(input logic q0, input logic q1);
        if (q0 && q1) begin
`ifdef DMEM_ARB_RR_EN
            return modelLast ? 0 : 1;
`else
            return 0;
`endif
        end
        return q0 ? 0 : 1;
    endfunction

    // One complete transaction from an IDLE cycle. mode: 0 holds the inputs,
    // 1 drops both requests during ACCESS, 2 randomises everything in ACCESS.
    task automatic doTxn(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input int mode);
        int          owner;
        logic        we;
        logic        inRange;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic [1:0]  ownerMask;

        applyStimulus(q0, w0, a0, d0, q1, w1, a1, d1);
        if (!q0 && !q1) begin
            @(posedge clk); #1;
            checkOutput("idle_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
            checkOutput("idle_en", {30'd0, bus.mem_ewr, bus.mem_erd}, 32'd0);
            return;
        end

        owner     = pickOwner(q0, q1);
        we        = (owner == 1) ? w1 : w0;
        addr      = (owner == 1) ? a1 : a0;
        wdata     = (owner == 1) ? d1 : d0;
        inRange   = (addr < 32);
        ownerMask = (owner == 1) ? 2'b10 : 2'b01;
        expRdata  = (!we && inRange) ? refMem[addr[4:0]] : 32'd0;

        @(posedge clk); #1;
        modelLast = (owner == 1);
        checkOutput("acc_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, {30'd0, ownerMask});
        checkOutput("acc_ewr", {31'd0, bus.mem_ewr}, {31'd0, we & inRange});
        checkOutput("acc_erd", {31'd0, bus.mem_erd}, {31'd0, ~we & inRange});
        checkOutput("acc_addr", bus.mem_addr, addr);
        checkOutput("acc_wdata", bus.mem_rdir, wdata);
        checkOutput("acc_done", {30'd0, bus.r1_done, bus.r0_done}, 32'd0);

        if (mode == 1) begin
            bus.r0_req = 1'b0;
            bus.r1_req = 1'b0;
        end else if (mode == 2) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 47), $urandom,
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 47), $urandom);
        end

        @(posedge clk); #1;
        checkOutput("resp_done", {30'd0, bus.r1_done, bus.r0_done}, {30'd0, ownerMask});
        checkOutput("resp_err", {30'd0, bus.r1_err, bus.r0_err}, inRange ? 32'd0 : {30'd0, ownerMask});
        checkOutput("resp_rdata", (owner == 1) ? bus.r1_rdata : bus.r0_rdata, expRdata);
        checkOutput("resp_rdata_other", (owner == 1) ? bus.r0_rdata : bus.r1_rdata, 32'd0);
        checkOutput("resp_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, {30'd0, ownerMask});
        checkOutput("resp_mem", {30'd0, bus.mem_ewr, bus.mem_erd}, 32'd0);
        checkOutput("resp_maddr", bus.mem_addr, 32'd0);
        if (we && inRange) refMem[addr[4:0]] = wdata;

        @(posedge clk); #1;
        checkAllZero("back_idle");
    endtask

    initial begin
        logic [31:0] resetData;
        checks    = 0;
        errors    = 0;
        modelLast = 1'b1;
        for (int i = 0; i < 32; i++) refMem[i] = 32'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held for two cycles; memory is cleared alongside.
        rst      = 1'b1;
        memClear = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst      = 1'b0;
        memClear = 1'b0;
        checkAllZero("reset");

        // Requester 0 writes, requester 1 reads it back.
        doTxn(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        doTxn(0, 0, 0, 0, 1, 0, 32'd5, 32'h0, 0);

        // Both requesting, inputs held: owner order comes from the model.
        for (int k = 0; k < 4; k++) begin
            doTxn(1, 0, 32'd5, 32'h0, 1, 0, 32'd5, 32'h0, 0);
        end

        // Out-of-range read.
        doTxn(1, 0, 32'd40, 32'h0, 0, 0, 0, 0, 0);

        // Reset during the ACCESS cycle of a requester-1 write to address 3.
        resetData = 32'hA5A5_0303;
        applyStimulus(0, 0, 0, 0, 1, 1, 32'd3, resetData);
        @(posedge clk); #1;
        checkOutput("rst_acc_ewr", {31'd0, bus.mem_ewr}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refMem[3] = resetData;
        modelLast = 1'b1;
        checkAllZero("rst_mid");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("rst_no_done", {30'd0, bus.r1_done, bus.r0_done}, 32'd0);
        doTxn(0, 0, 0, 0, 1, 0, 32'd3, 32'h0, 0);

        // Request dropped during ACCESS still completes.
        doTxn(1, 0, 32'd5, 32'h0, 0, 0, 0, 0, 1);

        // Randomised traffic, including idle cycles and out-of-range addresses.
        for (int k = 0; k < 60; k++) begin
            doTxn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 47), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 47), $urandom, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
